// File: rtl/addr_decoder_pkg.sv
// Shared constants and config-map offsets for the dock I/O address decoder.
package addr_decoder_pkg;

  localparam logic [7:0] OP_RW        = 8'hFF;
  localparam logic [7:0] OP_WO        = 8'h00;
  localparam logic [7:0] OP_RO        = 8'h01;
  localparam logic [7:0] OP_DIS       = 8'h80;
  localparam logic [7:0] IRQ_CFG_BASE = 8'hC0;

  function automatic int BASE_OFF(int cfg_bytes, int w, int b);
    return w * cfg_bytes + b;
  endfunction

  function automatic int MASK_OFF(int num_win, int cfg_bytes, int w, int b);
    return num_win * cfg_bytes + w * cfg_bytes + b;
  endfunction

  function automatic int SLOT_OFF(int num_win, int cfg_bytes, int w);
    return 2 * num_win * cfg_bytes + w;
  endfunction

  function automatic int OP_OFF(int num_win, int cfg_bytes, int w);
    return SLOT_OFF(num_win, cfg_bytes, 0) + num_win + w;
  endfunction

endpackage

// File: rtl/addr_decoder_win_match.sv
// Single decode window: base/mask compare qualified by the window's access direction.
module addr_win_match
  import addr_decoder_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] mask,
  input  logic [7:0]        op,
  input  logic              r_w_,
  output logic              hit
);

  logic addr_eq;
  logic dir_ok;

  assign addr_eq = ((addr & mask) == (base & mask));
  assign dir_ok  = (op == OP_RW) || (op == OP_WO && !r_w_) || (op == OP_RO && r_w_);
  assign hit     = addr_eq && dir_ok;

endmodule

// File: rtl/addr_decoder.sv
// Dock I/O address decoder: window match, slot chip selects, bridge/filler enables,
// merged ready and IRQ vector-fetch routing.
module addr_decoder
  import addr_decoder_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int NUM_WIN   = 16,
  parameter int NUM_SLOTS = 5,
  parameter int CFG_BYTES = (ADDR_W + 7) / 8,
  parameter int WIN_W     = $clog2(NUM_WIN),
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 iorq_n,
  input  logic                 r_w_,
  input  logic [NUM_SLOTS-1:0] dev_ready_n,
  input  logic                 irq_int_active,
  input  logic [2:0]           irq_int_slot,
  input  logic                 irq_vec_cycle,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_addr,
  input  logic [7:0]           cfg_wdata,
  output logic                 ready_n,
  output logic                 io_r_w_,
  output logic                 data_oe_n,
  output logic                 data_dir,
  output logic                 ff_oe_n,
  output logic                 win_valid,
  output logic [WIN_W-1:0]     win_index,
  output logic [SLOT_W-1:0]    sel_slot,
  output logic [NUM_SLOTS-1:0] cs_n
);

  logic [NUM_WIN-1:0][CFG_BYTES*8-1:0] base_q;
  logic [NUM_WIN-1:0][CFG_BYTES*8-1:0] mask_q;
  logic [NUM_WIN-1:0][SLOT_W-1:0]      slot_q;
  logic [NUM_WIN-1:0][7:0]             op_q;
  logic [NUM_WIN-1:0]                  hit;
  logic [NUM_SLOTS-1:0]                rdy_s1, rdy_s2;
  logic                                cfg_wr;
  logic                                active, vec, mapped, rd;
  logic [SLOT_W-1:0]                   slot_eff;

  // IRQ block owns 0xC0 and above
  assign cfg_wr = cfg_we && (cfg_addr < IRQ_CFG_BASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      mask_q <= '0;
      slot_q <= '0;
      for (int w = 0; w < NUM_WIN; w++) op_q[w] <= OP_DIS;
    end else if (cfg_wr) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        for (int b = 0; b < CFG_BYTES; b++) begin
          if (int'(cfg_addr) == BASE_OFF(CFG_BYTES, w, b))
            base_q[w][8*b +: 8] <= cfg_wdata;
          if (int'(cfg_addr) == MASK_OFF(NUM_WIN, CFG_BYTES, w, b))
            mask_q[w][8*b +: 8] <= cfg_wdata;
        end
        if (int'(cfg_addr) == SLOT_OFF(NUM_WIN, CFG_BYTES, w))
          slot_q[w] <= cfg_wdata[SLOT_W-1:0];
        if (int'(cfg_addr) == OP_OFF(NUM_WIN, CFG_BYTES, w))
          op_q[w] <= cfg_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_s1 <= '1;
      rdy_s2 <= '1;
    end else begin
      rdy_s1 <= dev_ready_n;
      rdy_s2 <= rdy_s1;
    end
  end

  for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
    addr_win_match #(.ADDR_W(ADDR_W)) u_match (
      .addr (addr),
      .base (base_q[w][ADDR_W-1:0]),
      .mask (mask_q[w][ADDR_W-1:0]),
      .op   (op_q[w]),
      .r_w_ (r_w_),
      .hit  (hit[w])
    );
  end

  // Scan from the top so the lowest-index hit is the last to write
  always_comb begin
    win_valid = 1'b0;
    win_index = '0;
    for (int w = NUM_WIN - 1; w >= 0; w--) begin
      if (hit[w]) begin
        win_valid = 1'b1;
        win_index = WIN_W'(w);
      end
    end
  end

  always_comb begin
    active = !iorq_n && !rst;
    vec    = active && irq_vec_cycle;
    if (vec) begin
      slot_eff = SLOT_W'(irq_int_slot);
      mapped   = irq_int_active && (int'(irq_int_slot) < NUM_SLOTS);
      rd       = 1'b1;
    end else begin
      slot_eff = win_valid ? slot_q[win_index] : '0;
      mapped   = active && win_valid && (int'(slot_q[win_index]) < NUM_SLOTS);
      rd       = r_w_;
    end
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_cs
    assign cs_n[s] = !(mapped && slot_eff == SLOT_W'(s));
  end

  assign sel_slot  = slot_eff;
  assign data_oe_n = !mapped;
  assign data_dir  = active && rd;
  assign ff_oe_n   = !(active && rd && !mapped);
  assign io_r_w_   = rst || r_w_;
  assign ready_n   = !(mapped && !rdy_s2[slot_eff]);

endmodule

// File: tb/tb_addr_decoder.sv
// Directed bench for addr_decoder: expectations queued by the stimulus, checked by a negedge monitor.
module tb_addr_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        iorq_n, r_w_;
  logic [4:0]  dev_ready_n;
  logic        irq_int_active, irq_vec_cycle;
  logic [2:0]  irq_int_slot;
  logic        cfg_we;
  logic [7:0]  cfg_addr, cfg_wdata;
  logic        ready_n, io_r_w_, data_oe_n, data_dir, ff_oe_n, win_valid;
  logic [3:0]  win_index;
  logic [2:0]  sel_slot;
  logic [4:0]  cs_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [4:0] cs;
    logic       oe, dir, ff, rdy, iorw, wv;
    logic [3:0] wi;
  } exp_t;

  exp_t exp_q[$];

  addr_decoder dut (
    .clk(clk), .rst(rst), .addr(addr), .iorq_n(iorq_n), .r_w_(r_w_),
    .dev_ready_n(dev_ready_n), .irq_int_active(irq_int_active),
    .irq_int_slot(irq_int_slot), .irq_vec_cycle(irq_vec_cycle),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .ready_n(ready_n), .io_r_w_(io_r_w_), .data_oe_n(data_oe_n),
    .data_dir(data_dir), .ff_oe_n(ff_oe_n), .win_valid(win_valid),
    .win_index(win_index), .sel_slot(sel_slot), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".cs_n"},      32'(cs_n),      32'(e.cs));
      chk({e.name, ".data_oe_n"}, 32'(data_oe_n), 32'(e.oe));
      chk({e.name, ".data_dir"},  32'(data_dir),  32'(e.dir));
      chk({e.name, ".ff_oe_n"},   32'(ff_oe_n),   32'(e.ff));
      chk({e.name, ".ready_n"},   32'(ready_n),   32'(e.rdy));
      chk({e.name, ".io_r_w_"},   32'(io_r_w_),   32'(e.iorw));
      chk({e.name, ".win_valid"}, 32'(win_valid), 32'(e.wv));
      chk({e.name, ".win_index"}, 32'(win_index), 32'(e.wi));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [4:0] cs, input logic oe, dir, ff,
                            rdy, wv, input logic [3:0] wi);
    exp_t e;
    e.name = nm; e.cs = cs; e.oe = oe; e.dir = dir; e.ff = ff; e.rdy = rdy;
    e.iorw = rst ? 1'b1 : r_w_;
    e.wv = wv; e.wi = wi;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input string nm, input logic [31:0] a, input logic rw, io, vec, act,
                     input logic [2:0] islot, input logic [4:0] cs, input logic oe, dir, ff,
                     rdy, wv, input logic [3:0] wi);
    tick();
    addr = a; r_w_ = rw; iorq_n = io;
    irq_vec_cycle = vec; irq_int_active = act; irq_int_slot = islot;
    expect_out(nm, cs, oe, dir, ff, rdy, wv, wi);
  endtask

  task automatic cfg_wr(input int a, input logic [7:0] d);
    tick();
    cfg_we = 1'b1; cfg_addr = 8'(a); cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic prog(input int w, input logic [31:0] base, input logic [7:0] slot,
                      input logic [7:0] op);
    logic [31:0] mask;
    mask = 32'hFFFF_FF00;
    for (int b = 0; b < 4; b++) begin
      cfg_wr(w * 4 + b, base[8*b +: 8]);
      cfg_wr(64 + w * 4 + b, mask[8*b +: 8]);
    end
    cfg_wr(128 + w, slot);
    cfg_wr(144 + w, op);
  endtask

  initial begin
    rst = 1'b1; addr = '0; iorq_n = 1'b1; r_w_ = 1'b1; dev_ready_n = '1;
    irq_int_active = 1'b0; irq_int_slot = '0; irq_vec_cycle = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

    tick();
    addr = 32'h1000_0000; iorq_n = 1'b0; r_w_ = 1'b0;
    expect_out("reset", 5'h1F, 1, 0, 1, 1, 0, 0);
    tick();
    rst = 1'b0; iorq_n = 1'b1; r_w_ = 1'b1; addr = '0;

    prog(0,  32'h1000_0000, 8'h00, 8'hFF);
    prog(1,  32'h1000_0100, 8'h00, 8'hFF);
    prog(2,  32'h1000_0200, 8'h00, 8'h00);
    prog(3,  32'h1000_0300, 8'h00, 8'h01);
    prog(4,  32'h2000_0000, 8'h01, 8'hFF);
    prog(5,  32'h2000_0100, 8'h01, 8'h00);
    prog(6,  32'h2000_0200, 8'h01, 8'h01);
    prog(7,  32'h2000_0300, 8'h01, 8'h00);
    prog(8,  32'h3000_0000, 8'hFA, 8'hFF);  // upper SLOT bits must be dropped -> slot 2
    prog(9,  32'h3000_0100, 8'h02, 8'hFF);
    prog(10, 32'h4000_0000, 8'h03, 8'hFF);
    prog(11, 32'h4000_0100, 8'h03, 8'hFF);
    prog(12, 32'hF000_0000, 8'h04, 8'hFF);
    prog(13, 32'hF000_0100, 8'h04, 8'hFF);
    prog(14, 32'hF000_0200, 8'h04, 8'h00);
    prog(15, 32'hF000_0300, 8'h04, 8'hFF);

    cyc("idle",     32'h0000_0000, 1, 1, 0, 0, 0, 5'h1F, 1, 0, 1, 1, 0, 0);
    cyc("t1_wr",    32'h1000_0004, 0, 0, 0, 0, 0, 5'h1E, 0, 0, 1, 1, 1, 0);
    cyc("t2_wr",    32'h1000_020A, 0, 0, 0, 0, 0, 5'h1E, 0, 0, 1, 1, 1, 2);
    cyc("t2_rd",    32'h1000_020A, 1, 0, 0, 0, 0, 5'h1F, 1, 1, 0, 1, 0, 0);
    cyc("t3_rd",    32'h1000_0300, 1, 0, 0, 0, 0, 5'h1E, 0, 1, 1, 1, 1, 3);
    cyc("t3_wr",    32'h1000_0300, 0, 0, 0, 0, 0, 5'h1F, 1, 0, 1, 1, 0, 0);

    tick();
    addr = 32'h2000_0000; r_w_ = 1'b0; iorq_n = 1'b0; dev_ready_n = 5'b11101;
    expect_out("t4_c0", 5'h1D, 0, 0, 1, 1, 1, 4);
    tick(); expect_out("t4_c1", 5'h1D, 0, 0, 1, 1, 1, 4);
    tick(); expect_out("t4_c2", 5'h1D, 0, 0, 1, 0, 1, 4);
    tick(); dev_ready_n = 5'b11111;
    expect_out("t4_rel0", 5'h1D, 0, 0, 1, 0, 1, 4);
    tick(); expect_out("t4_rel1", 5'h1D, 0, 0, 1, 0, 1, 4);
    tick(); expect_out("t4_rel2", 5'h1D, 0, 0, 1, 1, 1, 4);

    cyc("t5_f000",  32'hF000_0000, 1, 0, 0, 0, 0, 5'h0F, 0, 1, 1, 1, 1, 12);
    cyc("t5_f308",  32'hF000_0308, 1, 0, 0, 0, 0, 5'h0F, 0, 1, 1, 1, 1, 15);
    cyc("t5_f200",  32'hF000_0200, 1, 0, 0, 0, 0, 5'h1F, 1, 1, 0, 1, 0, 0);
    cyc("t6_unm",   32'hDEAD_BEEF, 1, 0, 0, 0, 0, 5'h1F, 1, 1, 0, 1, 0, 0);
    cyc("t6_vec",   32'hDEAD_BEEF, 1, 0, 1, 1, 2, 5'h1B, 0, 1, 1, 1, 0, 0);
    cyc("vec_idle", 32'hDEAD_BEEF, 1, 0, 1, 0, 2, 5'h1F, 1, 1, 0, 1, 0, 0);
    cyc("vec_s5",   32'hDEAD_BEEF, 1, 0, 1, 1, 5, 5'h1F, 1, 1, 0, 1, 0, 0);
    cyc("unm_wr",   32'h5555_0000, 0, 0, 0, 0, 0, 5'h1F, 1, 0, 1, 1, 0, 0);
    cyc("slot_msk", 32'h3000_0010, 1, 0, 0, 0, 0, 5'h1B, 0, 1, 1, 1, 1, 8);
    cyc("iorq_hi",  32'h2000_0000, 0, 1, 0, 0, 0, 5'h1F, 1, 0, 1, 1, 1, 4);

    cfg_wr(128 + 9, 8'h07);
    cyc("slot7",    32'h3000_0100, 1, 0, 0, 0, 0, 5'h1F, 1, 1, 0, 1, 1, 9);

    tick();
    addr = 32'h1000_0004; r_w_ = 1'b0; iorq_n = 1'b0;
    cfg_we = 1'b1; cfg_addr = 8'd144; cfg_wdata = 8'h80;
    expect_out("cfg_old", 5'h1E, 0, 0, 1, 1, 1, 0);
    tick(); cfg_we = 1'b0;
    expect_out("cfg_new", 5'h1F, 1, 0, 1, 1, 0, 0);

    cyc("pre_rst",  32'hF000_0000, 1, 0, 0, 0, 0, 5'h0F, 0, 1, 1, 1, 1, 12);
    tick(); rst = 1'b1;
    expect_out("rst_mid", 5'h1F, 1, 0, 1, 1, 0, 0);
    tick(); rst = 1'b0; iorq_n = 1'b1;

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
